// File: rtl/ecc_24_wr_enc.sv
// ecc_24_wr_enc: write side of an ECC-protected storage queue.
// Each accepted 24-bit word is encoded into a 30-bit codeword,
// {parity[5:0], data[23:0]}, and presented to the storage write port
// one cycle later. The block also keeps the wrapped write pointer and
// derives occupancy and full from the read pointer it is given.
// Optional build macro: ECC_24_ERR_INJ_EN enables the single-bit and
// double-bit data corruption controls used to exercise the decoder.
module ecc_24_wr_enc #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [23:0]           in_data,
  input  logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [29:0]           mem_wdata,
  input  logic                  inj_sbit,
  input  logic                  inj_dbit
);

  localparam int PW = ADDR_WIDTH + 1;

  // Occupancy at which the storage is exactly full (2^ADDR_WIDTH).
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Data bits covered by each parity bit.
  localparam logic [23:0] P0_MASK = 24'hAAAD5B;
  localparam logic [23:0] P1_MASK = 24'h33366D;
  localparam logic [23:0] P2_MASK = 24'hC3C78E;
  localparam logic [23:0] P3_MASK = 24'hFC07F0;
  localparam logic [23:0] P4_MASK = 24'hFFF800;
  localparam logic [23:0] P5_MASK = 24'hA65CB7;

  logic        accept;
  logic [5:0]  parity;
  logic [23:0] store_data;

  // Occupancy is a plain modulo difference. Any value above DEPTH can only
  // come from an illegal rd_ptr, and it is treated as full so that nothing
  // gets overwritten.
  assign count    = wr_ptr - rd_ptr;
  assign full     = (count >= DEPTH);
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;

  // Parity is always taken from the word as presented, never from the
  // corrupted copy, so that an injected error shows up as a real error.
  assign parity = {^(in_data & P5_MASK), ^(in_data & P4_MASK),
                   ^(in_data & P3_MASK), ^(in_data & P2_MASK),
                   ^(in_data & P1_MASK), ^(in_data & P0_MASK)};

`ifdef ECC_24_ERR_INJ_EN
  logic [23:0] inj_mask;

  // Pick the corruption pattern. A double-bit request overrides a single-bit one.
  always_comb begin
    // NOTE: assigning a default first means every path drives inj_mask, so no latch is inferred.
    inj_mask = 24'h000000;
    if (inj_dbit) begin
      inj_mask = 24'h000003;
    end else if (inj_sbit) begin
      inj_mask = 24'h000001;
    end
  end

  assign store_data = in_data ^ inj_mask;
`else
  // With injection disabled the request pins are kept only so the port list
  // does not change between builds. They drive nothing.
  logic unused_inj;
  assign unused_inj = inj_sbit | inj_dbit;
  assign store_data = in_data;
`endif

  // Register the write-port outputs and advance the write pointer on accept.
  // The reset is asynchronous, so a pending write is dropped the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: use non-blocking assignments for all state so that every flop samples the pre-edge values.
      wr_ptr    <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_wdata <= {parity, store_data};
        mem_waddr <= wr_ptr[ADDR_WIDTH-1:0];
        wr_ptr    <= wr_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ecc_24_wr_enc.sv
// tb_ecc_24_wr_enc: self-checking bench for ecc_24_wr_enc (ADDR_WIDTH=4).
// Expected codewords come from an independent bit-list parity model and
// are queued on accept. A negedge monitor pops the queue on every mem_we.
module tb_ecc_24_wr_enc;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [23:0]   in_data = '0;
  logic [PW-1:0] rd_ptr = '0;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] count;
  logic          full;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [29:0]   mem_wdata;
  logic          inj_sbit = 1'b0;
  logic          inj_dbit = 1'b0;

  ecc_24_wr_enc #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rd_ptr    (rd_ptr),
    .wr_ptr    (wr_ptr),
    .count     (count),
    .full      (full),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .inj_sbit  (inj_sbit),
    .inj_dbit  (inj_dbit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [29:0]   data;
  } wr_t;

  wr_t           sb[$];
  wr_t           exp_wr;
  int            checks = 0;
  int            errors = 0;
  int            wr_cnt = 0;
  logic          exp_we = 1'b0;
  logic [PW-1:0] model_wr = '0;

  // Bit positions for each parity bit. A value of -1 pads the shorter lists.
  int sets [6][14] = '{
    '{0, 1, 3, 4, 6, 8, 10, 11, 13, 15, 17, 19, 21, 23},
    '{0, 2, 3, 5, 6, 9, 10, 12, 13, 16, 17, 20, 21, -1},
    '{1, 2, 3, 7, 8, 9, 10, 14, 15, 16, 17, 22, 23, -1},
    '{4, 5, 6, 7, 8, 9, 10, 18, 19, 20, 21, 22, 23, -1},
    '{11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21, 22, 23, -1},
    '{0, 1, 2, 4, 5, 7, 10, 11, 12, 14, 17, 18, 21, 23}
  };

  function automatic logic [29:0] model_cw(logic [23:0] d, logic s, logic b);
    logic [5:0]  p;
    logic [23:0] st;
    p  = '0;
    st = d;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 14; j++)
        if (sets[i][j] >= 0) p[i] = p[i] ^ d[sets[i][j]];
`ifdef ECC_24_ERR_INJ_EN
    if (b) st = st ^ 24'h3;
    else if (s) st = st ^ 24'h1;
`endif
    return {p, st};
  endfunction

  // Scoreboard monitor: compares every write and the pointer against the model.
  always @(negedge clk) begin
    checks++;
    if (mem_we !== exp_we) begin
      errors++;
      $display("FAIL mem_we got %b want %b at %0t", mem_we, exp_we, $time);
    end
    checks++;
    if (wr_ptr !== model_wr) begin
      errors++;
      $display("FAIL wr_ptr got %0d want %0d at %0t", wr_ptr, model_wr, $time);
    end
    if (mem_we === 1'b1) begin
      wr_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr %0d data %h at %0t", mem_waddr, mem_wdata, $time);
      end else begin
        exp_wr = sb.pop_front();
        if (mem_waddr !== exp_wr.addr || mem_wdata !== exp_wr.data) begin
          errors++;
          $display("FAIL write got %0d/%h want %0d/%h", mem_waddr, mem_wdata, exp_wr.addr, exp_wr.data);
        end
      end
    end
  end

  // Runs one clock cycle. It starts and ends 1 time unit after a rising edge.
  task automatic drive(input logic v, input logic [23:0] d, input logic s, input logic b);
    logic [PW-1:0] occ;
    logic          acc;
    in_valid = v;
    in_data  = d;
    inj_sbit = s;
    inj_dbit = b;
    #1;
    occ = model_wr - rd_ptr;
    acc = v && (occ < DEPTH);
    checks++;
    if (in_ready !== (occ < DEPTH)) begin
      errors++;
      $display("FAIL in_ready got %b want %b", in_ready, (occ < DEPTH));
    end
    checks++;
    if (count !== occ) begin
      errors++;
      $display("FAIL count got %0d want %0d", count, occ);
    end
    if (acc) sb.push_back(wr_t'{model_wr[AW-1:0], model_cw(d, s, b)});
    @(posedge clk);
    #1;
    exp_we = acc;
    if (acc) model_wr = model_wr + 1'b1;
    in_valid = 1'b0;
    inj_sbit = 1'b0;
    inj_dbit = 1'b0;
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    exp_we   = 1'b0;
    model_wr = '0;
    sb.delete();
    rd_ptr   = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    rd_ptr = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wr_ptr !== 5'd0 || mem_we !== 1'b0 || mem_waddr !== 4'd0 || mem_wdata !== 30'd0) begin
      errors++;
      $display("FAIL reset_regs got %0d/%b/%0d/%h want 0/0/0/0", wr_ptr, mem_we, mem_waddr, mem_wdata);
    end
    checks++;
    if (count !== 5'd27 || full !== 1'b1) begin
      errors++;
      $display("FAIL reset_illegal_occ got %0d/%b want 27/1", count, full);
    end
    rd_ptr = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_first_accept();
    drive(1'b1, 24'h000000, 1'b0, 1'b0);
    checks++;
    if (mem_we !== 1'b1 || mem_waddr !== 4'd0 || mem_wdata !== 30'h0 || wr_ptr !== 5'd1) begin
      errors++;
      $display("FAIL first_accept got %b/%0d/%h/%0d want 1/0/0/1", mem_we, mem_waddr, mem_wdata, wr_ptr);
    end
  endtask

  task automatic test_vectors();
    drive(1'b1, 24'h000001, 1'b0, 1'b0);
    checks++;
    if (mem_wdata !== 30'h23000001) begin
      errors++;
      $display("FAIL vec_000001 got %h want 23000001", mem_wdata);
    end
    drive(1'b1, 24'hFFFFFF, 1'b0, 1'b0);
    checks++;
    if (mem_wdata !== 30'h1EFFFFFF) begin
      errors++;
      $display("FAIL vec_ffffff got %h want 1effffff", mem_wdata);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 24'($urandom), 1'b0, 1'b0);
    drive(1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic test_injection();
    logic [29:0] want_s;
    logic [29:0] want_d;
`ifdef ECC_24_ERR_INJ_EN
    want_s = 30'h1;
    want_d = 30'h3;
`else
    want_s = 30'h0;
    want_d = 30'h0;
`endif
    drive(1'b1, 24'h000000, 1'b1, 1'b0);
    checks++;
    if (mem_wdata !== want_s) begin
      errors++;
      $display("FAIL inj_sbit got %h want %h", mem_wdata, want_s);
    end
    drive(1'b1, 24'h000000, 1'b1, 1'b1);
    checks++;
    if (mem_wdata !== want_d) begin
      errors++;
      $display("FAIL inj_both got %h want %h", mem_wdata, want_d);
    end
    drive(1'b1, 24'h000000, 1'b0, 1'b1);
    checks++;
    if (mem_wdata !== want_d) begin
      errors++;
      $display("FAIL inj_dbit got %h want %h", mem_wdata, want_d);
    end
    drive(1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 24'($urandom), 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== 5'd16) begin
      errors++;
      $display("FAIL full_state got %b/%b/%0d want 1/0/16", full, in_ready, count);
    end
    // A 17th valid is refused. The monitor flags it if it is written anyway.
    drive(1'b1, 24'h5A5A5A, 1'b0, 1'b0);
    rd_ptr = 5'd1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_read got %b/%b want 1/0", in_ready, full);
    end
    drive(1'b1, 24'h123456, 1'b0, 1'b0);
    drive(1'b1, 24'h654321, 1'b0, 1'b0);
    drive(1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int start_cnt;
    apply_reset();
    start_cnt = wr_cnt;
    for (int i = 0; i < 40; i++) begin
      rd_ptr = model_wr - 5'd2;
      drive(1'b1, 24'($urandom), 1'b0, 1'b0);
      if (i == 16) begin
        checks++;
        if (mem_waddr !== 4'd0) begin
          errors++;
          $display("FAIL waddr_wrap got %0d want 0", mem_waddr);
        end
      end
      if (i == 31) begin
        checks++;
        if (wr_ptr !== 5'd0 || mem_waddr !== 4'd15) begin
          errors++;
          $display("FAIL wr_ptr_wrap got %0d/%0d want 0/15", wr_ptr, mem_waddr);
        end
      end
    end
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    checks++;
    if (wr_cnt - start_cnt != 40) begin
      errors++;
      $display("FAIL b2b_writes got %0d want 40", wr_cnt - start_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int start_cnt;
    apply_reset();
    drive(1'b1, 24'hABCDEF, 1'b0, 1'b0);
    start_cnt = wr_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || wr_ptr !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid got %b/%0d want 0/0", mem_we, wr_ptr);
    end
    exp_we   = 1'b0;
    model_wr = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 24'h0, 1'b0, 1'b0);
    checks++;
    if (wr_cnt != start_cnt) begin
      errors++;
      $display("FAIL reset_mid_writes got %0d want %0d", wr_cnt - start_cnt, 0);
    end
  endtask

  initial begin
    test_reset();
    test_first_accept();
    test_vectors();
    test_injection();
    test_full();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
